// File: rtl/cv32e40p_pkg2.sv
// Shared constants and types for the fault-tolerant IF-stage voters.
// Each triplicated IF sub-block has its own set of breakage-counter
// constants. The instantiating block passes them to
// cv32e40p_ft_voter_monitor as parameters.
// Ports: none (package).
package cv32e40p_pkg2;

  // Generic defaults shared by every IF-stage voter.
  localparam int unsigned FT_DEFAULT_COUNT_BIT          = 8;
  localparam int unsigned FT_DEFAULT_INC_DEC_BIT        = 2;
  localparam int unsigned FT_DEFAULT_INCREMENT          = 1;
  localparam int unsigned FT_DEFAULT_DECREMENT          = 1;
  localparam int unsigned FT_DEFAULT_BREAKING_THRESHOLD = 3;

  // Per-instance constants, one set for each voted IF-stage block.
  localparam int unsigned PREFETCH_COUNT_BIT          = 8;
  localparam int unsigned PREFETCH_INC_DEC_BIT        = 2;
  localparam int unsigned PREFETCH_INCREMENT          = 1;
  localparam int unsigned PREFETCH_DECREMENT          = 1;
  localparam int unsigned PREFETCH_BREAKING_THRESHOLD = 3;

  localparam int unsigned ALIGNER_COUNT_BIT          = 8;
  localparam int unsigned ALIGNER_INC_DEC_BIT        = 2;
  localparam int unsigned ALIGNER_INCREMENT          = 1;
  localparam int unsigned ALIGNER_DECREMENT          = 1;
  localparam int unsigned ALIGNER_BREAKING_THRESHOLD = 3;

  localparam int unsigned PC_DEF_COUNT_BIT          = 8;
  localparam int unsigned PC_DEF_INC_DEC_BIT        = 2;
  localparam int unsigned PC_DEF_INCREMENT          = 1;
  localparam int unsigned PC_DEF_DECREMENT          = 1;
  localparam int unsigned PC_DEF_BREAKING_THRESHOLD = 3;

  // Health of one replica, derived from its counter and broken flag.
  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    BROKEN  = 2'd2
  } ft_rep_state_e;

  function automatic ft_rep_state_e ft_rep_state(input logic broken, input logic cnt_zero);
    if (broken) return BROKEN;
    if (cnt_zero) return HEALTHY;
    return SUSPECT;
  endfunction

endpackage

// File: rtl/cv32e40p_breakage_counter.sv
// Saturating breakage counter and sticky broken flag for one replica.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear_i     - synchronous clear of counter and broken flag (beats en_i)
//   en_i        - sample-valid; the counter moves only when high
//   mismatch_i  - this replica disagrees with the voted value
//   cnt_o       - current counter value
//   broken_o    - sticky broken flag
module cv32e40p_breakage_counter
  import cv32e40p_pkg2::*;
#(
  parameter int unsigned COUNT_BIT          = FT_DEFAULT_COUNT_BIT,
  parameter int unsigned INC_DEC_BIT        = FT_DEFAULT_INC_DEC_BIT,
  parameter int unsigned INCREMENT          = FT_DEFAULT_INCREMENT,
  parameter int unsigned DECREMENT          = FT_DEFAULT_DECREMENT,
  parameter int unsigned BREAKING_THRESHOLD = FT_DEFAULT_BREAKING_THRESHOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic                 mismatch_i,
  output logic [COUNT_BIT-1:0] cnt_o,
  output logic                 broken_o
);

  // Steps and bounds are held one bit wider than the counter, so the
  // saturation tests see the true sum/difference before truncation.
  localparam logic [INC_DEC_BIT-1:0] INC_STEP = INC_DEC_BIT'(INCREMENT);
  localparam logic [INC_DEC_BIT-1:0] DEC_STEP = INC_DEC_BIT'(DECREMENT);
  localparam logic [COUNT_BIT:0]     INC_EXT  = (COUNT_BIT+1)'(INC_STEP);
  localparam logic [COUNT_BIT:0]     DEC_EXT  = (COUNT_BIT+1)'(DEC_STEP);
  localparam logic [COUNT_BIT:0]     CNT_MAX  = {1'b0, {COUNT_BIT{1'b1}}};
  localparam logic [COUNT_BIT:0]     TH_EXT   = (COUNT_BIT+1)'(BREAKING_THRESHOLD);

  logic [COUNT_BIT-1:0] cnt_reg, cnt_next;
  logic                 broken_reg, broken_next;
  logic [COUNT_BIT:0]   cnt_ext, cnt_sum, cnt_step;
  ft_rep_state_e        state;

  assign cnt_ext = {1'b0, cnt_reg};
  assign cnt_sum = cnt_ext + INC_EXT;

  always_comb begin
    cnt_step = cnt_ext;
    if (mismatch_i) begin
      cnt_step = (cnt_sum > CNT_MAX) ? CNT_MAX : cnt_sum;
    end else begin
      cnt_step = (cnt_ext < DEC_EXT) ? '0 : (cnt_ext - DEC_EXT);
    end
  end

  always_comb begin
    cnt_next    = cnt_reg;
    broken_next = broken_reg;
    if (clear_i) begin
      cnt_next    = '0;
      broken_next = 1'b0;
    end else if (en_i && !broken_reg) begin
      cnt_next = cnt_step[COUNT_BIT-1:0];
      // The flag is set on the same edge that the counter reaches the threshold.
      if (cnt_step >= TH_EXT) broken_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      broken_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      broken_reg <= broken_next;
    end
  end

  assign cnt_o    = cnt_reg;
  assign broken_o = broken_reg;

  assign state = ft_rep_state(broken_reg, cnt_reg == '0);

  // A broken replica stays broken until it is cleared or reset.
  broken_absorbing_a : assert property (@(posedge clk) disable iff (!rst_n)
    (state == BROKEN && !clear_i) |=> (state == BROKEN));

endmodule

// File: rtl/cv32e40p_ft_voter_monitor.sv
// Voter and health monitor for one triplicated IF-stage signal.
// Healthy replicas are voted. Replicas whose breakage counter reaches the
// threshold are marked broken and are left out of the vote.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   en_i            - sample-valid strobe for the counters
//   clear_i         - synchronous clear of all counters and broken flags
//   data_i[2:0]     - replica inputs
//   data_o          - voted value (combinational)
//   err_detected_o  - per-replica mismatch against data_o, healthy replicas only
//   no_majority_o   - healthy replicas contain no equal pair
//   broken_o        - sticky broken flags
//   count_o[2:0]    - breakage counter values
module cv32e40p_ft_voter_monitor
  import cv32e40p_pkg2::*;
#(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned COUNT_BIT          = FT_DEFAULT_COUNT_BIT,
  parameter int unsigned INC_DEC_BIT        = FT_DEFAULT_INC_DEC_BIT,
  parameter int unsigned INCREMENT          = FT_DEFAULT_INCREMENT,
  parameter int unsigned DECREMENT          = FT_DEFAULT_DECREMENT,
  parameter int unsigned BREAKING_THRESHOLD = FT_DEFAULT_BREAKING_THRESHOLD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      clear_i,
  input  logic [2:0][WIDTH-1:0]     data_i,
  output logic [WIDTH-1:0]          data_o,
  output logic [2:0]                err_detected_o,
  output logic                      no_majority_o,
  output logic [2:0]                broken_o,
  output logic [2:0][COUNT_BIT-1:0] count_o
);

  logic [2:0]       broken;
  logic [WIDTH-1:0] majority;
  logic [WIDTH-1:0] voted;
  logic             no_majority;
  logic [2:0]       err;

  assign majority = (data_i[0] & data_i[1]) | (data_i[0] & data_i[2]) | (data_i[1] & data_i[2]);

  // With one replica broken the two survivors cannot out-vote each other.
  // The lower-index survivor is trusted. With all three broken, fall back
  // to plain majority.
  always_comb begin
    voted       = majority;
    no_majority = 1'b0;
    case (broken)
      3'b000: begin
        voted       = majority;
        no_majority = (data_i[0] != data_i[1]) && (data_i[0] != data_i[2]) &&
                      (data_i[1] != data_i[2]);
      end
      3'b001: begin
        voted       = data_i[1];
        no_majority = (data_i[1] != data_i[2]);
      end
      3'b010: begin
        voted       = data_i[0];
        no_majority = (data_i[0] != data_i[2]);
      end
      3'b100: begin
        voted       = data_i[0];
        no_majority = (data_i[0] != data_i[1]);
      end
      3'b011:  voted = data_i[2];
      3'b101:  voted = data_i[1];
      3'b110:  voted = data_i[0];
      default: voted = majority;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rep
      assign err[gi] = (data_i[gi] != voted) && !broken[gi];

      cv32e40p_breakage_counter #(
        .COUNT_BIT          (COUNT_BIT),
        .INC_DEC_BIT        (INC_DEC_BIT),
        .INCREMENT          (INCREMENT),
        .DECREMENT          (DECREMENT),
        .BREAKING_THRESHOLD (BREAKING_THRESHOLD)
      ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear_i),
        .en_i       (en_i),
        .mismatch_i (err[gi]),
        .cnt_o      (count_o[gi]),
        .broken_o   (broken[gi])
      );
    end
  endgenerate

  assign data_o         = voted;
  assign err_detected_o = err;
  assign no_majority_o  = no_majority;
  assign broken_o       = broken;

endmodule
